// File: rtl/systolic_feeder_4x4.sv
// Operand scheduler for the 4x4 systolic array.
// Latches one A/B block pair and feeds it diagonally skewed onto the west and north lanes.
module systolic_feeder_4x4 #(
    parameter int BIT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*BIT_WIDTH-1:0] a_blk,
    input  logic [16*BIT_WIDTH-1:0] b_blk,
    output logic [BIT_WIDTH-1:0]    west_out0,
    output logic [BIT_WIDTH-1:0]    west_out1,
    output logic [BIT_WIDTH-1:0]    west_out2,
    output logic [BIT_WIDTH-1:0]    west_out3,
    output logic [BIT_WIDTH-1:0]    north_out0,
    output logic [BIT_WIDTH-1:0]    north_out1,
    output logic [BIT_WIDTH-1:0]    north_out2,
    output logic [BIT_WIDTH-1:0]    north_out3,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] FEED_LAST  = 4'd6;
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [15:0][BIT_WIDTH-1:0] a_q, a_d;
    logic [15:0][BIT_WIDTH-1:0] b_q, b_d;
    logic [3:0][BIT_WIDTH-1:0] west_q, west_d;
    logic [3:0][BIT_WIDTH-1:0] north_q, north_d;
    logic [3:0][3:0] off;
    logic in_ready_q, in_ready_d;
    logic acc_clr_q, acc_clr_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic accept;

    assign accept = (state_q == S_IDLE) && in_ready_q && in_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Element n of the packed bus sits MSB-first, so element 0 is the top slice.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (accept) begin
            for (int n = 0; n < 16; n++) begin
                a_d[n] = a_blk[(15-n)*BIT_WIDTH +: BIT_WIDTH];
                b_d[n] = b_blk[(15-n)*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Lane i carries operand index t-i; a negative offset wraps above 3 and is masked.
    always_comb begin
        west_d  = '0;
        north_d = '0;
        off     = '0;
        for (int i = 0; i < 4; i++) begin
            off[i] = cnt_d - 4'(i);
            if (state_d == S_FEED && off[i] < 4'd4) begin
                west_d[i]  = a_q[{2'(i), off[i][1:0]}];
                north_d[i] = b_q[{off[i][1:0], 2'(i)}];
            end
        end
    end

    always_comb begin
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        acc_clr_d  = (state_d == S_CLEAR);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            west_q     <= '0;
            north_q    <= '0;
            in_ready_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            west_q     <= west_d;
            north_q    <= north_d;
            in_ready_q <= in_ready_d;
            acc_clr_q  <= acc_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign acc_clr    = acc_clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign west_out0  = west_q[0];
    assign west_out1  = west_q[1];
    assign west_out2  = west_q[2];
    assign west_out3  = west_q[3];
    assign north_out0 = north_q[0];
    assign north_out1 = north_q[1];
    assign north_out2 = north_q[2];
    assign north_out3 = north_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Scoreboard bench for systolic_feeder_4x4: per-cycle expected outputs
// are queued at block acceptance and compared on the falling edge.
module tb_systolic_feeder_4x4;

    localparam int BW = 16;

    typedef struct packed {
        logic [3:0][BW-1:0] w;
        logic [3:0][BW-1:0] n;
        logic clr;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_valid1 = 1'b0;
    logic [16*BW-1:0] a_blk = '0;
    logic [16*BW-1:0] b_blk = '0;

    logic in_ready, acc_clr, busy, done;
    logic [BW-1:0] w0, w1, w2, w3, n0, n1, n2, n3;
    logic in_ready1, acc_clr1, busy1, done1;
    logic [BW-1:0] x0, x1, x2, x3, y0, y1, y2, y3;

    int total = 0;
    int bad = 0;
    exp_t q[$];
    logic [15:0] ma [16];
    logic [15:0] mb [16];

    systolic_feeder_4x4 #(.BIT_WIDTH(BW), .DRAIN_CYCLES(6)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_blk(a_blk), .b_blk(b_blk),
        .west_out0(w0), .west_out1(w1), .west_out2(w2), .west_out3(w3),
        .north_out0(n0), .north_out1(n1), .north_out2(n2), .north_out3(n3),
        .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    systolic_feeder_4x4 #(.BIT_WIDTH(BW), .DRAIN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_blk(a_blk), .b_blk(b_blk),
        .west_out0(x0), .west_out1(x1), .west_out2(x2), .west_out3(x3),
        .north_out0(y0), .north_out1(y1), .north_out2(y2), .north_out3(y3),
        .acc_clr(acc_clr1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic exp_t sample0();
        exp_t o;
        o.w[0] = w0; o.w[1] = w1; o.w[2] = w2; o.w[3] = w3;
        o.n[0] = n0; o.n[1] = n1; o.n[2] = n2; o.n[3] = n3;
        o.clr = acc_clr; o.busy = busy; o.done = done; o.rdy = in_ready;
        return o;
    endfunction

    function automatic exp_t sample1();
        exp_t o;
        o.w[0] = x0; o.w[1] = x1; o.w[2] = x2; o.w[3] = x3;
        o.n[0] = y0; o.n[1] = y1; o.n[2] = y2; o.n[3] = y3;
        o.clr = acc_clr1; o.busy = busy1; o.done = done1; o.rdy = in_ready1;
        return o;
    endfunction

    function automatic logic [16*BW-1:0] pack(input logic [15:0] e [16]);
        logic [16*BW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[(15-k)*BW +: BW] = e[k];
        return v;
    endfunction

    // Expected outputs for cycles C+1 .. C+10+d of a block held in ma/mb.
    task automatic push_block(input int d);
        exp_t e;
        int t, k;
        for (int c = 1; c <= 10 + d; c++) begin
            e = '0;
            e.clr  = (c == 1);
            e.busy = (c <= 9 + d);
            e.done = (c == 9 + d);
            e.rdy  = (c == 10 + d);
            if (c >= 2 && c <= 8) begin
                t = c - 2;
                for (int i = 0; i < 4; i++) begin
                    k = t - i;
                    if (k >= 0 && k <= 3) begin
                        e.w[i] = ma[4*i + k];
                        e.n[i] = mb[4*k + i];
                    end
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic scramble_bus();
        for (int k = 0; k < 8; k++) begin
            a_blk[32*k +: 32] = $urandom();
            b_blk[32*k +: 32] = $urandom();
        end
    endtask

    task automatic random_block();
        for (int k = 0; k < 16; k++) begin
            ma[k] = 16'($urandom());
            mb[k] = 16'($urandom());
        end
    endtask

    // Offers ma/mb to the main DUT, which is expected to be ready now.
    task automatic start_block();
        a_blk = pack(ma);
        b_blk = pack(mb);
        in_valid = 1'b1;
        push_block(6);
        step();
        in_valid = 1'b0;
        scramble_bus();
    endtask

    task automatic test_reset();
        exp_t obs, e;
        random_block();
        a_blk = pack(ma);
        b_blk = pack(mb);
        in_valid = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = sample0();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold c=%0d got=%h want=0", c, obs);
            end
        end
        rst = 1'b0;
        step();
        obs = sample0();
        e = '0;
        e.rdy = 1'b1;
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs, e);
        end
        push_block(6);
        step();
        in_valid = 1'b0;
        scramble_bus();
        for (int c = 1; c <= 16; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_first c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
    endtask

    task automatic test_identity_ramp();
        exp_t obs, e;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[4*i+k] = (i == k) ? 16'h0100 : 16'h0000;
                mb[4*i+k] = 16'(4*i + k + 1);
            end
        start_block();
        for (int c = 1; c <= 16; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL ident c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
    endtask

    task automatic test_skew_map();
        exp_t obs, e;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[4*i+k] = 16'(32'h1000 + 16*i + k);
                mb[4*i+k] = 16'(32'h2000 + 16*i + k);
            end
        start_block();
        for (int c = 1; c <= 16; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL skew c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t obs, e;
        random_block();
        start_block();
        for (int c = 1; c <= 32; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL backpress c=%0d got=%h want=%h", c, obs, e);
            end
            if (c == 3) begin
                random_block();
                a_blk = pack(ma);
                b_blk = pack(mb);
                in_valid = 1'b1;
            end
            if (c == 16) push_block(6);
            if (c == 17) begin
                in_valid = 1'b0;
                scramble_bus();
            end
            step();
        end
    endtask

    task automatic test_reset_mid_feed();
        exp_t obs, e;
        for (int k = 0; k < 16; k++) begin
            ma[k] = 16'(32'hA000 + k);
            mb[k] = 16'(32'hB000 + k);
        end
        start_block();
        for (int c = 1; c <= 4; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL midrst_pre c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
        rst = 1'b1;
        #1;
        q.delete();
        obs = sample0();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midrst_async got=%h want=0", obs);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            obs = sample0();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL midrst_hold c=%0d got=%h want=0", c, obs);
            end
        end
        rst = 1'b0;
        step();
        obs = sample0();
        e = '0;
        e.rdy = 1'b1;
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL midrst_release got=%h want=%h", obs, e);
        end
        random_block();
        start_block();
        for (int c = 1; c <= 16; c++) begin
            obs = sample0();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL midrst_fresh c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
    endtask

    task automatic test_drain_one();
        exp_t obs, e;
        random_block();
        a_blk = pack(ma);
        b_blk = pack(mb);
        in_valid1 = 1'b1;
        push_block(1);
        step();
        in_valid1 = 1'b0;
        scramble_bus();
        for (int c = 1; c <= 11; c++) begin
            obs = sample1();
            e = q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL drain1 c=%0d got=%h want=%h", c, obs, e);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_identity_ramp();
        test_skew_map();
        test_back_to_back();
        test_reset_mid_feed();
        test_drain_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_4x4.md
# systolic_feeder_4x4

Operand scheduler that drives the north/west edges of the 4x4 fixed-point systolic array. It accepts one 4x4 A block and one 4x4 B block over a valid/ready handshake. It then emits them with the diagonal skew the array requires: row i of A is delayed i cycles on west lane i, and column j of B is delayed j cycles on north lane j. It pulses an accumulator clear before the feed and a `done` strobe once the array's registered row outputs hold the finished block product.

## Interface
- `BIT_WIDTH`, 16, element width; fixed-point format is irrelevant here because the block only moves data.
- `DRAIN_CYCLES`, 6, cycles waited after the last feed beat before `done`; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; one clock domain.
- `in_valid`  in  1  an A/B block pair is offered.
- `in_ready`  out  1  feeder can accept a block.
- `a_blk`  in  16*BIT_WIDTH  A, row-major, MSB-first: A[i][k] at `a_blk[(15-(4*i+k))*BIT_WIDTH +: BIT_WIDTH]`.
- `b_blk`  in  16*BIT_WIDTH  B, same packing: B[k][j] at index 4*k+j.
- `west_out0..3`  out  BIT_WIDTH each  lane i drives array `west_in{i}`.
- `north_out0..3`  out  BIT_WIDTH each  lane j drives array `north_in{j}`.
- `acc_clr`  out  1  one-cycle pulse; the top level uses it to clear PE accumulators.
- `busy`  out  1  high from acceptance until `done` inclusive.
- `done`  out  1  one-cycle pulse; array row0..row3 are valid in this cycle.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `a_blk`/`b_blk` into internal registers and go to CLEAR.
- CLEAR: 1 cycle, `acc_clr`=1, then FEED with beat counter t=0.
- FEED: 7 beats, t=0..6.
  - `west_out{i}` = A[i][t-i] if 0 <= t-i <= 3, else 0.
  - `north_out{j}` = B[t-j][j] if 0 <= t-j <= 3, else 0.
  - After t=6, go to DRAIN.
- DRAIN:
  - `DRAIN_CYCLES` cycles.
  - All lanes 0.
  - Internal counter counts 0..DRAIN_CYCLES-1, then go to DONE.
- DONE: 1 cycle, `done`=1, all lanes 0, then IDLE.
- Lanes are exactly 0 in every non-FEED state and for every out-of-window beat. No stale data may leak from the latched block.
- `in_valid` while `in_ready`=0 is ignored. Neither `a_blk` nor `b_blk` is sampled.
- Latched operands are stable for the whole transaction. Input buses may change freely after the accept edge.
- Elements are passed bit-exact; no arithmetic, sign handling or rounding.

## Timing
- All outputs are registered, driven from state and counters; no combinational input-to-output path, including `in_ready`.
- Reset values (asynchronous, immediate):
  - state=IDLE.
  - `in_ready`=0; it becomes 1 in the first cycle after `rst` deasserts.
  - All lanes=0, `acc_clr`=0, `busy`=0, `done`=0.
- Let C be the cycle in which `in_valid && in_ready` is sampled high.
  - C+1: `acc_clr`=1, `busy`=1, `in_ready`=0.
  - C+2..C+8: feed beats t=0..6, one per cycle.
  - C+9..C+8+DRAIN_CYCLES: drain.
  - C+9+DRAIN_CYCLES: `done`=1.
  - C+10+DRAIN_CYCLES: `in_ready`=1, `busy`=0.
- Throughput: one block per 10+DRAIN_CYCLES cycles. No overlap between blocks.
- Reset asserted mid-transaction, in any state:
  - Outputs return to reset values asynchronously.
  - The latched block is discarded.
  - No `done` pulse is ever issued for that block.
- `in_valid` held high continuously: the next block is accepted in the cycle `in_ready` returns to 1, never earlier.

## Test plan
- Reset check: assert `rst` for 3 cycles with `in_valid`=1 -> all outputs 0 during reset; `in_ready`=1 one cycle after release; a block is accepted on the next edge.
- Identity × ramp: A=I (diagonal 0x0100, else 0), B[k][j]=4k+j+1 -> `acc_clr` at C+1.
  - `west_out0` = 0x0100,0,0,0,0,0,0.
  - `west_out3` = 0,0,0,0,0,0,0x0100.
  - `north_out1` = 0,0x0002,0x0006,0x000A,0x000E,0,0.
  - `done` at C+15; array rows equal B.
- Full skew map: A[i][k]=0x1000+16i+k, B[k][j]=0x2000+16k+j -> every lane/beat matches the window formula; every out-of-window beat is 0.
- Backpressure: a second block is offered at C+3 with `in_valid` held high -> ignored until C+16, accepted there; second `acc_clr` at C+17; first block's data never appears after C+8.
- Reset mid-FEED: assert `rst` at C+5 -> lanes 0 immediately; no `done` pulse; a fresh block after release completes with the correct sequence.
- DRAIN_CYCLES=1 build: `done` at C+10; `busy` high exactly C+1..C+10.
